sram_1rw_wmask_init: RTL
========================

Name: sram_1rw_wmask_init

Overview:
Parametrised single-port read/write SRAM macro model. It is the successor to the fixed 32x128 1rw SRAM and shares its clk0/csb0/web0/addr0/din0/dout0 port convention. New features:
- per-lane write mask
- selectable read latency (1 or 2)
- read-valid strobe
- hardware clear-on-reset sequencer that zeroes the array and reports busy0 until done

It sits in the SRAM benchmark family as the baseline clean memory used by the SoC-level benches.

Parameters:
DATA_WIDTH, 32, data word width in bits; must be a multiple of WMASK_WIDTH
ADDR_WIDTH, 7, address width; DEPTH = 2**ADDR_WIDTH words (derived localparam, not overridable)
WMASK_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_WIDTH (derived)
READ_LAT, 1, read latency in clk0 edges; legal values 1 or 2, anything else is an elaboration error
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset release; 0 = no clear, ready immediately

Ports:
clk0  in  1  clock; all state changes on rising edge
rst0_n  in  1  reset, asynchronous assert, active low
csb0  in  1  chip select, active low
web0  in  1  write enable, active low (1 = read)
wmask0  in  NUM_WMASKS  per-lane write enable, bit i covers din0[i*WMASK_WIDTH +: WMASK_WIDTH]
addr0  in  ADDR_WIDTH  word address
din0  in  DATA_WIDTH  write data
dout0  out  DATA_WIDTH  read data
rvalid0  out  1  one-cycle pulse, coincident with new dout0
busy0  out  1  clear sequence in progress; accesses ignored

Behaviour:
- Reset (rst0_n=0, async):
  - dout0=0, rvalid0=0, read pipeline flushed.
  - Clear counter=0.
  - FSM=INIT and busy0=1 if CLEAR_ON_RESET=1; otherwise FSM=READY and busy0=0.
  - The array itself is not reset; it is only zeroed by the sequencer.
- FSM states and transitions:
  - INIT: each rising edge writes all-zero to array[clr_cnt], then clr_cnt+1. On the edge that writes DEPTH-1 go to READY; busy0 falls on that same edge. busy0 is therefore high for exactly DEPTH edges after release.
  - READY: normal access. No exit except reset.
- Reset mid-INIT: the counter restarts at 0 and the full clear repeats.
- Access qualification: an access is valid when csb0=0 && busy0=0, sampled at the rising edge.
  - Accesses while busy0=1 are dropped silently: no write, no rvalid0.
- Write (valid, web0=0): for each lane i with wmask0[i]=1, array[addr0] lane i <= din0 lane i. Other lanes are unchanged. wmask0=0 is a legal no-op write. dout0 and rvalid0 are unaffected (no write-through).
- Read (valid, web0=1):
  - READ_LAT=1: dout0 <= array[addr0] at the same edge; rvalid0=1 for the following cycle.
  - READ_LAT=2: data is staged through one internal register and appears one edge later, with rvalid0 aligned to it.
  - Back-to-back reads are fully pipelined, one per cycle.
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- dout0 holds the last read data until the next read completes; it is never driven X after reset.
- csb0=1: no operation; addr0, din0 and wmask0 are don't-care.
- Address space is a full power of two; there is no out-of-range case and addr0 wraps naturally.
- Simultaneous events:
  - The sequencer owns the write port in INIT.
  - Reads issued in the last INIT cycle (busy0 still 1 at the edge) are dropped.

Decomposition:
- Package sram_pkg:
  - FSM state enum (INIT, READY)
  - function num_wmasks(data_w, lane_w)
  - localparam for legal READ_LAT range
- Sub-module sram_init_ctrl:
  - clear FSM, counter and busy0 generation
  - outputs a write-port override (en, addr, zero data, full mask) muxed in front of the array
- Array, mask merge and read pipeline stay in the top module.

Test Plan:
- Clear after reset: DEPTH=128, CLEAR_ON_RESET=1; release rst0_n -> busy0 high for exactly 128 edges. Then read addr 0, 0x55, 0x7F -> dout0=0x00000000 each, with rvalid0 pulsed.
- Basic write/read: write 0xFACECAFE to addr 10 with wmask0=4'hF; read addr 10 -> dout0=0xFACECAFE. READ_LAT=1 data appears after 1 edge; READ_LAT=2 after 2 edges.
- Masked write: addr 5 holds 0x11223344; write 0xAABBCCDD with wmask0=4'b0101 -> read gives 0x11BB33DD.
- Busy drop: issue a write of 0xDEADBEEF to addr 3 during INIT -> after clear, read addr 3 = 0, and no rvalid0 appeared while busy0 was high.
- Reset mid-clear: assert rst0_n low at clear count 60 for 2 cycles -> dout0=0 and rvalid0=0 immediately; after release busy0 is high a full 128 edges again.
- Pipelined reads: write addr i = i for i = 0..31, then read 0..31 back-to-back -> dout0 sequence 0..31 on consecutive cycles, rvalid0 continuously high for 32 cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1rw write-masked SRAM model with clear sequencer.
package sram_pkg;

  // Clear sequencer states.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Legal range of the READ_LAT parameter.
  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  // Number of write-mask lanes in a data word.
  function automatic int unsigned num_wmasks(input int unsigned data_w,
                                             input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Clear-on-reset sequencer: walks every address once after reset release,
// owning the array write port while busy.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   busy         registered, high while the clear walk is in progress
//   clr_en_c     write-port override enable (decoded from state)
//   clr_addr     address being cleared (counter)
//   clr_data_c   override write data (all zero)
//   clr_mask_c   override write mask (all lanes)
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WMASKS     = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  busy,
  output logic                  clr_en_c,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [DATA_WIDTH-1:0] clr_data_c,
  output logic [NUM_WMASKS-1:0] clr_mask_c
);

  localparam clr_state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
  localparam logic                  RST_BUSY  = (CLEAR_ON_RESET != 0);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = '1;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  // State, counter and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= RST_BUSY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: one address per edge; busy drops on the edge clearing the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy       = busy_q;
  assign clr_en_c   = (state_q == ST_INIT);
  assign clr_addr   = cnt_q;
  assign clr_data_c = '0;
  assign clr_mask_c = '1;

endmodule

// File: rtl/sram_1rw_wmask_init.sv
// Single-port SRAM model with per-lane write mask, 1- or 2-edge read latency,
// read-valid strobe and a hardware clear-on-reset sequencer.
// Ports:
//   clk0, rst0_n  clock, async active-low reset
//   csb0, web0    chip select / write enable, both active low
//   wmask0        per-lane write enable
//   addr0, din0   word address, write data
//   dout0         read data, held until the next read completes
//   rvalid0       one-cycle pulse with each new dout0
//   busy0         clear in progress; accesses dropped
module sram_1rw_wmask_init
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned WMASK_WIDTH    = 8,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                              clk0,
  input  logic                              rst0_n,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [DATA_WIDTH-1:0]             din0,
  output logic [DATA_WIDTH-1:0]             dout0,
  output logic                              rvalid0,
  output logic                              busy0
);

  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_WIDTH);

  // Reject illegal parameterisations at elaboration.
  if ((READ_LAT < READ_LAT_MIN) || (READ_LAT > READ_LAT_MAX)) begin : g_bad_read_lat
    $error("sram_1rw_wmask_init: READ_LAT must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_wmask
    $error("sram_1rw_wmask_init: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_en_c;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data_c;
  logic [NUM_WMASKS-1:0] clr_mask_c;

  sram_init_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_WMASKS     (NUM_WMASKS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_ctrl (
    .clk        (clk0),
    .rst_n      (rst0_n),
    .busy       (busy0),
    .clr_en_c   (clr_en_c),
    .clr_addr   (clr_addr),
    .clr_data_c (clr_data_c),
    .clr_mask_c (clr_mask_c)
  );

  logic                  rd_en_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NUM_WMASKS-1:0] wr_mask_c;

  assign rd_en_c   = !csb0 && web0 && !busy0;
  assign rd_data_c = mem[addr0];

  // Write-port mux: the sequencer owns the port while clearing.
  always_comb begin
    wr_en_c   = !csb0 && !web0 && !busy0;
    wr_addr_c = addr0;
    wr_data_c = din0;
    wr_mask_c = wmask0;
    if (clr_en_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_addr;
      wr_data_c = clr_data_c;
      wr_mask_c = clr_mask_c;
    end
  end

  // Array write with lane merge; the array itself is never reset.
  always_ff @(posedge clk0) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wr_mask_c[i]) begin
          mem[wr_addr_c][i*WMASK_WIDTH +: WMASK_WIDTH] <= wr_data_c[i*WMASK_WIDTH +: WMASK_WIDTH];
        end
      end
    end
  end

  // Read pipeline; dout0 only updates when a read completes.
  if (READ_LAT == 1) begin : g_lat1
    always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
        dout0   <= '0;
        rvalid0 <= 1'b0;
      end else begin
        rvalid0 <= rd_en_c;
        if (rd_en_c) dout0 <= rd_data_c;
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] stage_q;
    logic                  stage_v;
    always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
        stage_q <= '0;
        stage_v <= 1'b0;
        dout0   <= '0;
        rvalid0 <= 1'b0;
      end else begin
        stage_v <= rd_en_c;
        if (rd_en_c) stage_q <= rd_data_c;
        rvalid0 <= stage_v;
        if (stage_v) dout0 <= stage_q;
      end
    end
  end

endmodule
